// File: rtl/event_encoder_queue.sv
// Edge-detecting priority encoder: rising edges on d0..d7 become pending events
// that drain, highest line first, into a 4-entry FIFO of 3-bit line codes.
module event_encoder_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       d4,
    input  logic       d5,
    input  logic       d6,
    input  logic       d7,
    output logic [2:0] y,
    output logic       vld,
    input  logic       rdy,
    output logic       full,
    output logic       merged
);

    logic [7:0] lines;
    logic [7:0] prev_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] mem_q [0:3];
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] count_q, count_d;
    logic       merged_q, merged_d;

    logic [7:0] rise;
    logic [7:0] clearMask;
    logic [2:0] pushIdx;
    logic       push;
    logic       pop;

    assign lines = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign rise  = lines & ~prev_q;

    // Ascending scan so the highest set pending bit ends up selected.
    always_comb begin
        pushIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                pushIdx = 3'(i);
            end
        end
    end

    always_comb begin
        push      = (pending_q != 8'd0) && (count_q < 3'(DEPTH));
        pop       = vld && rdy;
        clearMask = push ? (8'd1 << pushIdx) : 8'd0;
        // A fresh rise re-arms a bit even if it is being pushed this cycle.
        pending_d = (pending_q & ~clearMask) | rise;
        merged_d  = |(rise & pending_q & ~clearMask);
        wptr_d    = push ? wptr_q + 2'd1 : wptr_q;
        rptr_d    = pop ? rptr_q + 2'd1 : rptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 8'd0;
            pending_q <= 8'd0;
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            count_q   <= 3'd0;
            merged_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            prev_q    <= lines;
            pending_q <= pending_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            merged_q  <= merged_d;
            if (push) begin
                mem_q[wptr_q] <= pushIdx;
            end
        end
    end

    assign vld    = (count_q != 3'd0);
    assign full   = (count_q == 3'(DEPTH));
    assign y      = vld ? mem_q[rptr_q] : 3'd0;
    assign merged = merged_q;

endmodule

// File: tb/tb_event_encoder_queue.sv
// Scoreboard bench for event_encoder_queue: directed line patterns push expected
// codes; a negedge monitor pops and compares on every accepted head.
module tb_event_encoder_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] y;
    logic       vld;
    logic       full;
    logic       merged;

    int         tests = 0;
    int         fails = 0;
    int         mergedCount = 0;
    logic [2:0] sb [$];

    always #5 clk = ~clk;

    event_encoder_queue #(.DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d0     (d[0]),
        .d1     (d[1]),
        .d2     (d[2]),
        .d3     (d[3]),
        .d4     (d[4]),
        .d5     (d[5]),
        .d6     (d[6]),
        .d7     (d[7]),
        .y      (y),
        .vld    (vld),
        .rdy    (rdy),
        .full   (full),
        .merged (merged)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] dv, input logic rdyv);
        d   = dv;
        rdy = rdyv;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain timeout", sb.size(), 0);
        end else begin
            tick(1);
        end
    endtask

    // Head is accepted at the next rising edge when vld && rdy at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vld === 1'b1 && rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected code", {29'd0, y}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("head code", {29'd0, y}, {29'd0, sb.pop_front()});
                end
            end
            if (vld === 1'b0) begin
                checkOutput("y idle zero", {29'd0, y}, 0);
            end
            if (merged === 1'b1) begin
                mergedCount++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b0);
        #12;
        checkOutput("reset vld", vld, 0);
        checkOutput("reset y", y, 0);
        checkOutput("reset full", full, 0);
        checkOutput("reset merged", merged, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single event on d7, latency and one-shot behaviour while held.
        applyStimulus(8'h80, 1'b1);
        sb.push_back(3'd7);
        tick(1);
        checkOutput("single vld edge1", vld, 0);
        tick(1);
        checkOutput("single vld edge2", vld, 1);
        checkOutput("single y edge2", y, 7);
        tick(1);
        checkOutput("single vld edge3", vld, 0);
        tick(5);
        applyStimulus(8'h00, 1'b1);
        tick(2);

        // All lines rise together with the consumer stalled.
        mergedCount = 0;
        applyStimulus(8'hFF, 1'b0);
        for (int i = 7; i >= 0; i--) sb.push_back(3'(i));
        tick(5);
        checkOutput("simul full", full, 1);
        checkOutput("simul head", y, 7);
        tick(3);
        checkOutput("simul still full", full, 1);
        applyStimulus(8'hFF, 1'b1);
        waitDrain(40);
        checkOutput("simul vld after", vld, 0);
        checkOutput("simul full after", full, 0);
        checkOutput("simul no merge", mergedCount, 0);
        applyStimulus(8'h00, 1'b1);
        tick(2);

        // Re-rise on d2 while its pending bit is stuck behind a full queue.
        mergedCount = 0;
        applyStimulus(8'hF4, 1'b0);
        sb.push_back(3'd7);
        sb.push_back(3'd6);
        sb.push_back(3'd5);
        sb.push_back(3'd4);
        sb.push_back(3'd2);
        tick(6);
        checkOutput("merge full", full, 1);
        applyStimulus(8'hF0, 1'b0);
        tick(1);
        applyStimulus(8'hF4, 1'b0);
        tick(1);
        checkOutput("merge pulse", merged, 1);
        tick(1);
        checkOutput("merge pulse end", merged, 0);
        applyStimulus(8'hF4, 1'b1);
        waitDrain(40);
        applyStimulus(8'h00, 1'b1);
        tick(3);
        checkOutput("merge count", mergedCount, 1);
        checkOutput("merge vld after", vld, 0);

        // One event per cycle with a ready consumer; pointers wrap.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'd1 << (i % 8), 1'b1);
            sb.push_back(3'(i % 8));
            tick(1);
            checkOutput("stream not full", full, 0);
        end
        applyStimulus(8'h00, 1'b1);
        waitDrain(20);
        checkOutput("stream vld after", vld, 0);

        // Asynchronous reset with three codes queued.
        applyStimulus(8'h0B, 1'b0);
        tick(5);
        checkOutput("prereset vld", vld, 1);
        checkOutput("prereset head", y, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset vld", vld, 0);
        checkOutput("midreset y", y, 0);
        checkOutput("midreset full", full, 0);
        applyStimulus(8'h00, 1'b0);
        tick(2);
        rst_n = 1'b1;
        applyStimulus(8'h00, 1'b1);
        tick(8);
        checkOutput("postreset vld", vld, 0);

        // Line already high when reset releases yields one event.
        rst_n = 1'b0;
        applyStimulus(8'h20, 1'b1);
        tick(2);
        rst_n = 1'b1;
        sb.push_back(3'd5);
        waitDrain(10);
        tick(5);
        checkOutput("held5 vld after", vld, 0);
        applyStimulus(8'h00, 1'b1);
        tick(2);

        checkOutput("scoreboard empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
